// File: rtl/in_fifo_gearbox_pkg.sv
// Shared constants and count helper for the receive-side nibble-to-byte gearbox FIFO.
package in_fifo_gearbox_pkg;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;

    localparam logic MODE_4X8 = 1'b1;
    localparam logic MODE_4X4 = 1'b0;

    function automatic logic [CNT_W-1:0] calc_next_count(
        input logic [CNT_W-1:0] count,
        input logic             enq,
        input logic             deq
    );
        logic [CNT_W-1:0] result;
        case ({enq, deq})
            2'b10:   result = count + 4'd1;
            2'b01:   result = count - 4'd1;
            default: result = count;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/in_fifo_gearbox_mem.sv
// Eight-entry storage array for the gearbox FIFO: one synchronous write port, one
// asynchronous read port, no reset on the data.
module in_fifo_gearbox_mem
    import in_fifo_gearbox_pkg::*;
#(
    parameter int WIDTH = 80
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_wptr,
    input  logic [WIDTH-1:0] i_data,
    input  logic [PTR_W-1:0] i_rptr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage write
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wptr] <= i_data;
        end
    end

    assign o_rdata = r_mem[i_rptr];

endmodule

// File: rtl/in_fifo_gearbox.sv
// Receive-side width-up FIFO: packs nibble pairs per lane into bytes, 8-deep, with status flags.
// Optional sticky OVERFLOW/UNDERFLOW outputs are enabled by IN_FIFO_GEARBOX_ERR_FLAGS_EN.
module in_fifo_gearbox
    import in_fifo_gearbox_pkg::*;
#(
    parameter int    NUM_LANES          = 10,
    parameter string ARRAY_MODE         = "ARRAY_MODE_4_X_8",
    parameter int    ALMOST_EMPTY_VALUE = 1,
    parameter int    ALMOST_FULL_VALUE  = 1,
    parameter string OUTPUT_DISABLE     = "FALSE"
) (
    input  logic                   CLK,
    input  logic                   RESETB,
    input  logic                   WREN,
    input  logic [4*NUM_LANES-1:0] D,
    input  logic                   RDEN,
    output logic [8*NUM_LANES-1:0] Q,
    output logic                   EMPTY,
    output logic                   FULL,
    output logic                   ALMOSTEMPTY,
`ifdef IN_FIFO_GEARBOX_ERR_FLAGS_EN
    output logic                   OVERFLOW,
    output logic                   UNDERFLOW,
`endif
    output logic                   ALMOSTFULL
);

    localparam int   DW      = 4 * NUM_LANES;
    localparam int   QW      = 8 * NUM_LANES;
    localparam logic MODE    = (ARRAY_MODE == "ARRAY_MODE_4_X_8") ? MODE_4X8 : MODE_4X4;
    localparam logic OUT_DIS = (OUTPUT_DISABLE == "TRUE") ? 1'b1 : 1'b0;

    // Illegal configurations stop elaboration rather than build a silently wrong FIFO.
    if ((ARRAY_MODE != "ARRAY_MODE_4_X_8") && (ARRAY_MODE != "ARRAY_MODE_4_X_4")) begin : g_bad_mode
        $fatal(1, "in_fifo_gearbox: illegal ARRAY_MODE");
    end
    if ((ALMOST_EMPTY_VALUE < 1) || (ALMOST_EMPTY_VALUE > 2)) begin : g_bad_ae
        $fatal(1, "in_fifo_gearbox: ALMOST_EMPTY_VALUE must be 1..2");
    end
    if ((ALMOST_FULL_VALUE < 1) || (ALMOST_FULL_VALUE > 2)) begin : g_bad_af
        $fatal(1, "in_fifo_gearbox: ALMOST_FULL_VALUE must be 1..2");
    end

    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_enq;
    logic [QW-1:0]    w_wdata;
    logic [QW-1:0]    w_rdata;
    logic [CNT_W-1:0] w_next_count;

    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_phase;
    logic [DW-1:0]    r_hold;

    assign w_wr_ok      = WREN & ~FULL;
    assign w_rd_ok      = RDEN & ~EMPTY;
    assign w_enq        = w_wr_ok & ((MODE == MODE_4X4) | r_phase);
    assign w_next_count = calc_next_count(r_count, w_enq, w_rd_ok);

    // Per-lane byte assembly: the held (first) nibble always lands in bits [3:0]
    always_comb begin
        w_wdata = {QW{1'b0}};
        for (int l = 0; l < NUM_LANES; l++) begin
            if (MODE == MODE_4X8) begin
                w_wdata[8*l +: 8] = {D[4*l +: 4], r_hold[4*l +: 4]};
            end else begin
                w_wdata[8*l +: 8] = {4'b0000, D[4*l +: 4]};
            end
        end
    end

    // Nibble phase and hold register; a refused write leaves both untouched
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_phase <= 1'b0;
            r_hold  <= {DW{1'b0}};
        end else if (w_wr_ok && (MODE == MODE_4X8)) begin
            if (!r_phase) begin
                r_hold <= D;
            end
            r_phase <= ~r_phase;
        end
    end

    // Pointers, occupancy, registered flags and output word
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_wptr      <= {PTR_W{1'b0}};
            r_rptr      <= {PTR_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            Q           <= {QW{1'b0}};
            EMPTY       <= 1'b1;
            FULL        <= 1'b0;
            ALMOSTEMPTY <= 1'b1;
            ALMOSTFULL  <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + 3'd1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 3'd1;
                Q      <= OUT_DIS ? {QW{1'b0}} : w_rdata;
            end
            r_count     <= w_next_count;
            EMPTY       <= (w_next_count == 4'd0);
            FULL        <= (w_next_count == CNT_W'(DEPTH));
            ALMOSTEMPTY <= (w_next_count <= CNT_W'(ALMOST_EMPTY_VALUE));
            ALMOSTFULL  <= (w_next_count >= CNT_W'(DEPTH - ALMOST_FULL_VALUE));
        end
    end

`ifdef IN_FIFO_GEARBOX_ERR_FLAGS_EN
    // Sticky error flags, cleared only by reset
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (WREN && FULL) begin
                OVERFLOW <= 1'b1;
            end
            if (RDEN && EMPTY) begin
                UNDERFLOW <= 1'b1;
            end
        end
    end
`endif

    in_fifo_gearbox_mem #(
        .WIDTH (QW)
    ) u_mem (
        .i_clk   (CLK),
        .i_we    (w_enq),
        .i_wptr  (r_wptr),
        .i_data  (w_wdata),
        .i_rptr  (r_rptr),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_in_fifo_gearbox.sv
// Scoreboard bench for in_fifo_gearbox: one 4_X_8 and one 4_X_4 instance on a shared clock/reset.
// Covers IN_FIFO_GEARBOX_ERR_FLAGS_EN outputs when that macro is defined.
module tb_in_fifo_gearbox;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wren8, rden8, wren4, rden4;
    logic [39:0] d8, d4;
    logic [79:0] q8, q4;
    logic        empty8, full8, ae8, af8;
    logic        empty4, full4, ae4, af4;
`ifdef IN_FIFO_GEARBOX_ERR_FLAGS_EN
    logic        ovf8, udf8, ovf4, udf4;
`endif

    int          n_pass = 0;
    int          n_total = 0;

    logic [79:0] sb8[$];
    logic [79:0] sb4[$];
    int          cnt8, cnt4;
    logic        phase8;
    logic [39:0] hold8;
    logic [79:0] exp_q8, exp_q4;

    always #5 clk = ~clk;

    in_fifo_gearbox #(.ARRAY_MODE("ARRAY_MODE_4_X_8")) dut8 (
        .CLK(clk), .RESETB(rst_n), .WREN(wren8), .D(d8), .RDEN(rden8), .Q(q8),
        .EMPTY(empty8), .FULL(full8), .ALMOSTEMPTY(ae8),
`ifdef IN_FIFO_GEARBOX_ERR_FLAGS_EN
        .OVERFLOW(ovf8), .UNDERFLOW(udf8),
`endif
        .ALMOSTFULL(af8)
    );

    in_fifo_gearbox #(.ARRAY_MODE("ARRAY_MODE_4_X_4")) dut4 (
        .CLK(clk), .RESETB(rst_n), .WREN(wren4), .D(d4), .RDEN(rden4), .Q(q4),
        .EMPTY(empty4), .FULL(full4), .ALMOSTEMPTY(ae4),
`ifdef IN_FIFO_GEARBOX_ERR_FLAGS_EN
        .OVERFLOW(ovf4), .UNDERFLOW(udf4),
`endif
        .ALMOSTFULL(af4)
    );

    function automatic logic [79:0] pack_pair(input logic [39:0] hi, input logic [39:0] lo);
        logic [79:0] r;
        for (int l = 0; l < 10; l++) r[8*l +: 8] = {hi[4*l +: 4], lo[4*l +: 4]};
        return r;
    endfunction

    function automatic logic [79:0] widen(input logic [39:0] d);
        logic [79:0] r;
        for (int l = 0; l < 10; l++) r[8*l +: 8] = {4'b0000, d[4*l +: 4]};
        return r;
    endfunction

    function automatic logic [39:0] rnd40();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[39:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        sb8.delete(); sb4.delete();
        cnt8 = 0; cnt4 = 0; phase8 = 1'b0; hold8 = 40'h0;
        exp_q8 = 80'h0; exp_q4 = 80'h0;
    endtask

    // One cycle on the 4_X_8 instance, updating the reference model
    task automatic op8(input logic wr, input logic rd, input logic [39:0] d);
        logic deq, enq;
        logic [79:0] word;
        wren8 = wr; rden8 = rd; d8 = d;
        deq = rd && (cnt8 > 0);
        enq = 1'b0;
        word = 80'h0;
        if (wr && (cnt8 < 8)) begin
            if (phase8) begin
                enq = 1'b1; word = pack_pair(d, hold8); phase8 = 1'b0;
            end else begin
                hold8 = d; phase8 = 1'b1;
            end
        end
        if (deq) begin exp_q8 = sb8.pop_front(); cnt8--; end
        if (enq) begin sb8.push_back(word); cnt8++; end
        step();
        wren8 = 1'b0; rden8 = 1'b0;
    endtask

    // One cycle on the 4_X_4 instance, updating the reference model
    task automatic op4(input logic wr, input logic rd, input logic [39:0] d);
        logic deq, enq;
        wren4 = wr; rden4 = rd; d4 = d;
        deq = rd && (cnt4 > 0);
        enq = wr && (cnt4 < 8);
        if (deq) begin exp_q4 = sb4.pop_front(); cnt4--; end
        if (enq) begin sb4.push_back(widen(d)); cnt4++; end
        step();
        wren4 = 1'b0; rden4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wren8 = 1'b0; rden8 = 1'b0; wren4 = 1'b0; rden4 = 1'b0;
        d8 = 40'h0; d4 = 40'h0;
        model_clear();
        step(); step();
        rst_n = 1'b1;
        step();
        n_total++; if (empty8 !== 1'b1) $display("FAIL reset_empty8 got %b want 1", empty8); else n_pass++;
        n_total++; if (ae8 !== 1'b1) $display("FAIL reset_ae8 got %b want 1", ae8); else n_pass++;
        n_total++; if (full8 !== 1'b0) $display("FAIL reset_full8 got %b want 0", full8); else n_pass++;
        n_total++; if (af8 !== 1'b0) $display("FAIL reset_af8 got %b want 0", af8); else n_pass++;
        n_total++; if (q8 !== 80'h0) $display("FAIL reset_q8 got %h want 0", q8); else n_pass++;
        n_total++; if (empty4 !== 1'b1) $display("FAIL reset_empty4 got %b want 1", empty4); else n_pass++;
        n_total++; if (q4 !== 80'h0) $display("FAIL reset_q4 got %h want 0", q4); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            op8(1'b0, 1'b1, 40'h0);
            n_total++; if (q8 !== 80'h0) $display("FAIL idle_read_q8 got %h want 0", q8); else n_pass++;
            n_total++; if (empty8 !== 1'b1) $display("FAIL idle_read_empty8 got %b want 1", empty8); else n_pass++;
        end
`ifdef IN_FIFO_GEARBOX_ERR_FLAGS_EN
        n_total++; if (udf8 !== 1'b1) $display("FAIL underflow8 got %b want 1", udf8); else n_pass++;
        n_total++; if (ovf8 !== 1'b0) $display("FAIL overflow8_idle got %b want 0", ovf8); else n_pass++;
`endif
    endtask

    task automatic test_pack8();
        op8(1'b1, 1'b0, {10{4'hA}});
        n_total++; if (empty8 !== 1'b1) $display("FAIL pack_empty_after_first got %b want 1", empty8); else n_pass++;
        op8(1'b1, 1'b0, {10{4'h5}});
        n_total++; if (empty8 !== 1'b0) $display("FAIL pack_empty_after_second got %b want 0", empty8); else n_pass++;
        op8(1'b0, 1'b1, 40'h0);
        n_total++; if (q8[7:0] !== 8'h5A) $display("FAIL pack_lane0 got %h want 5a", q8[7:0]); else n_pass++;
        n_total++; if (q8 !== exp_q8) $display("FAIL pack_word got %h want %h", q8, exp_q8); else n_pass++;
        n_total++; if (empty8 !== 1'b1) $display("FAIL pack_empty_after_read got %b want 1", empty8); else n_pass++;
    endtask

    task automatic test_fill8();
        for (int i = 0; i < 16; i++) begin
            op8(1'b1, 1'b0, rnd40());
            n_total++; if (full8 !== (cnt8 == 8)) $display("FAIL fill_full cnt=%0d got %b", cnt8, full8); else n_pass++;
            n_total++; if (af8 !== (cnt8 >= 7)) $display("FAIL fill_af cnt=%0d got %b", cnt8, af8); else n_pass++;
            n_total++; if (ae8 !== (cnt8 <= 1)) $display("FAIL fill_ae cnt=%0d got %b", cnt8, ae8); else n_pass++;
            n_total++; if (empty8 !== (cnt8 == 0)) $display("FAIL fill_empty cnt=%0d got %b", cnt8, empty8); else n_pass++;
        end
        op8(1'b1, 1'b0, rnd40());
        n_total++; if (full8 !== 1'b1) $display("FAIL extra_write_full got %b want 1", full8); else n_pass++;
`ifdef IN_FIFO_GEARBOX_ERR_FLAGS_EN
        n_total++; if (ovf8 !== 1'b1) $display("FAIL overflow8 got %b want 1", ovf8); else n_pass++;
`endif
        for (int i = 0; i < 8; i++) begin
            op8(1'b0, 1'b1, 40'h0);
            n_total++; if (q8 !== exp_q8) $display("FAIL drain8[%0d] got %h want %h", i, q8, exp_q8); else n_pass++;
        end
        n_total++; if (empty8 !== 1'b1) $display("FAIL drain8_empty got %b want 1", empty8); else n_pass++;
        op8(1'b1, 1'b0, {10{4'h7}});
        op8(1'b1, 1'b0, {10{4'h8}});
        op8(1'b0, 1'b1, 40'h0);
        n_total++; if (q8 !== {10{8'h87}}) $display("FAIL post_drop_pack got %h want %h", q8, {10{8'h87}}); else n_pass++;
    endtask

    task automatic test_simul4();
        for (int i = 0; i < 8; i++) op4(1'b1, 1'b0, rnd40());
        n_total++; if (full4 !== 1'b1) $display("FAIL simul_full_before got %b want 1", full4); else n_pass++;
        op4(1'b1, 1'b1, {10{4'hF}});
        n_total++; if (full4 !== 1'b0) $display("FAIL simul_full_after got %b want 0", full4); else n_pass++;
        n_total++; if (af4 !== 1'b1) $display("FAIL simul_af got %b want 1", af4); else n_pass++;
        n_total++; if (q4 !== exp_q4) $display("FAIL simul_q got %h want %h", q4, exp_q4); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            op4(1'b0, 1'b1, 40'h0);
            n_total++; if (q4 !== exp_q4) $display("FAIL simul_drain[%0d] got %h want %h", i, q4, exp_q4); else n_pass++;
        end
        n_total++; if (empty4 !== 1'b1) $display("FAIL simul_empty got %b want 1", empty4); else n_pass++;
    endtask

    task automatic test_wrap4();
        logic [39:0] d;
        logic [3:0]  nib;
        for (int i = 0; i < 20; i++) begin
            nib = i[3:0];
            d = {10{nib}};
            op4(1'b1, 1'b0, d);
            op4(1'b0, 1'b1, 40'h0);
            n_total++; if (q4 !== exp_q4) $display("FAIL wrap[%0d] got %h want %h", i, q4, exp_q4); else n_pass++;
        end
    endtask

    task automatic test_reset_midpack();
        op8(1'b1, 1'b0, {10{4'h3}});
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_clear();
        step();
        n_total++; if (empty8 !== 1'b1) $display("FAIL midpack_empty got %b want 1", empty8); else n_pass++;
        n_total++; if (q8 !== 80'h0) $display("FAIL midpack_q_cleared got %h want 0", q8); else n_pass++;
        op8(1'b1, 1'b0, {10{4'h1}});
        op8(1'b1, 1'b0, {10{4'h2}});
        op8(1'b0, 1'b1, 40'h0);
        n_total++; if (q8 !== {10{8'h21}}) $display("FAIL midpack_q got %h want %h", q8, {10{8'h21}}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pack8();
        test_fill8();
        test_simul4();
        test_wrap4();
        test_reset_midpack();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
